// File: rtl/tdm_demux_pkg.sv
// Shared types and default sizing for the TDM receive demultiplexer.
// The demux holds this package's defaults unless its parameters override them.
package tdm_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int NCH_DEF = 4;
  localparam int W_DEF   = 8;

  // A counter for a range of one value still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int CNT_W = clog2_min1(W_DEF);

endpackage

// File: rtl/tdm_demux_chan_shift.sv
// One channel's MSB-first shift register, with a clear used to discard partial frames.
// nxt exposes the post-shift value so the frame can be captured on the edge that shifts in the last bit.
module chan_shift
  import tdm_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt
);

  assign nxt = {q[W-2:0], d};

  // Clear with enable seeds a new frame: the register restarts holding only this bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= {W{1'b0}};
    end else if (clr) begin
      q <= en ? {{(W-1){1'b0}}, d} : {W{1'b0}};
    end else if (en) begin
      q <= nxt;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: steers a framed serial stream into NCH channel
// registers and presents each complete frame in parallel with a one-cycle valid pulse.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   bit_en,
  input  logic                   ser_in,
  input  logic                   sync_in,
  output logic [NCH*W-1:0]       par_out,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic [$clog2(NCH)-1:0] chan_sel
);

  localparam int BIT_W = clog2_min1(W);
  localparam int CH_W  = clog2_min1(NCH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);

  state_t            state_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [CH_W-1:0]   ch_cnt_r;
  logic              start_s;
  logic              advance_s;
  logic [CH_W-1:0]   tgt_ch_s;
  logic [NCH-1:0]    en_s;
  logic [W-1:0]      sh_q   [NCH];
  logic [W-1:0]      sh_nxt [NCH];
  logic [NCH*W-1:0]  frame_s;

  // A sync bit always starts a frame; ordinary bits only count while receiving.
  always_comb begin
    start_s   = bit_en & sync_in;
    advance_s = bit_en & ~sync_in & (state_r == RECV);
    if (start_s) begin
      tgt_ch_s = {CH_W{1'b0}};
    end else begin
      tgt_ch_s = ch_cnt_r;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign en_s[i] = (start_s | advance_s) & (tgt_ch_s == CH_W'(i));
    // Only the channel taking the current bit differs from its stored value.
    assign frame_s[W*i +: W] = en_s[i] ? sh_nxt[i] : sh_q[i];

    chan_shift #(.W(W)) u_chan (
      .clk    (clk),
      .resetn (resetn),
      .clr    (start_s),
      .en     (en_s[i]),
      .d      (ser_in),
      .q      (sh_q[i]),
      .nxt    (sh_nxt[i])
    );
  end

  // Frame FSM, bit/channel counters, frame capture and pulse outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      bit_cnt_r   <= {BIT_W{1'b0}};
      ch_cnt_r    <= {CH_W{1'b0}};
      par_out     <= {(NCH*W){1'b0}};
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (start_s) begin
        frame_err <= (state_r == RECV);
        state_r   <= RECV;
        bit_cnt_r <= BIT_W'(1);
        ch_cnt_r  <= {CH_W{1'b0}};
      end else if (advance_s) begin
        if (bit_cnt_r == BIT_LAST) begin
          bit_cnt_r <= {BIT_W{1'b0}};
          if (ch_cnt_r == CH_LAST) begin
            ch_cnt_r    <= {CH_W{1'b0}};
            par_out     <= frame_s;
            frame_valid <= 1'b1;
            state_r     <= IDLE;
          end else begin
            ch_cnt_r <= ch_cnt_r + CH_W'(1);
          end
        end else begin
          bit_cnt_r <= bit_cnt_r + BIT_W'(1);
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign chan_sel = ch_cnt_r;

endmodule
